// File: rtl/controlador_barrido_display_pkg.sv
// Shared types and constants for the 7-segment scan controller.
// Segment codes are active-low {g,f,e,d,c,b,a}; anodes are active-low.
package disp_pkg;

   typedef enum logic {BLANK = 1'b0, ON = 1'b1} state_e;

   localparam logic [6:0] SEG_OFF = 7'h7F;
   localparam logic [7:0] AN_OFF  = 8'hFF;

   localparam logic [6:0] SEG_TABLE [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   // A digit is blanked when it and every digit above it are zero; digit 0 always shows.
   function automatic logic [7:0] lz_mask(input logic [31:0] digits, input int n, input logic en);
      logic [7:0] mask;
      logic       seen;
      mask = '0;
      seen = 1'b0;
      for (int i = 7; i >= 1; i--) begin
         if (i < n) begin
            if (digits[4*i +: 4] != 4'h0) seen = 1'b1;
            mask[i] = en & ~seen;
         end
      end
      return mask;
   endfunction

endpackage

// File: rtl/controlador_barrido_display_if.sv
// Load handshake between the upstream digit source and the scan controller.
interface controlador_barrido_display_if #(parameter int N_DIGITS = 8) ();

   logic                    load_valid;
   logic [4*N_DIGITS-1:0]   load_data;
   logic                    load_ready;
   logic                    lz_en;

   modport master (output load_valid, output load_data, output lz_en, input load_ready);
   modport slave  (input load_valid, input load_data, input lz_en, output load_ready);

endinterface

// File: rtl/controlador_barrido_display_hex_a_7seg.sv
// Combinational hex nibble to active-low 7-segment pattern.
module hex_a_7seg
   import disp_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/controlador_barrido_display.sv
// Time-multiplexed 8-digit common-anode scan controller with a blank guard between
// digit slots and a shadow buffer committed only at frame boundaries.
module controlador_barrido_display
   import disp_pkg::*;
#(
   parameter int N_DIGITS = 8,
   parameter int DIV      = 100000,
   parameter int GUARD    = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   controlador_barrido_display_if.slave  load_if,
   output logic [7:0]                    anodo,
   output logic [6:0]                    catodos,
   output logic                          frame_done
);

   localparam int              DW         = 4*N_DIGITS;
   localparam int              CW         = $clog2(((DIV > GUARD) ? DIV : GUARD) + 1);
   localparam logic [CW-1:0]   DIV_LAST   = CW'(DIV - 1);
   localparam logic [CW-1:0]   GUARD_LAST = CW'(GUARD - 1);
   localparam logic [2:0]      IDX_LAST   = 3'(N_DIGITS - 1);

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      idx_q, idx_d;
   logic [DW-1:0]   active_q, active_d;
   logic [DW-1:0]   pending_q, pending_d;
   logic            pending_full_q, pending_full_d;
   logic [7:0]      mask_q, mask_d;
   logic [7:0]      anodo_q, anodo_d;
   logic [6:0]      catodos_q, catodos_d;
   logic            load_ready_q, load_ready_d;
   logic            frame_done_q, frame_done_d;

   logic            accept;
   logic            frame_end;
   logic [31:0]     active_ext;
   logic [3:0]      nibble;
   logic [6:0]      seg;

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      idx_d          = idx_q;
      active_d       = active_q;
      pending_d      = pending_q;
      pending_full_d = pending_full_q;
      mask_d         = mask_q;
      frame_done_d   = 1'b0;

      accept    = load_if.load_valid && load_ready_q;
      frame_end = (state_q == ON) && (cnt_q == DIV_LAST) && (idx_q == IDX_LAST);

      case (state_q)
         BLANK: begin
            if (cnt_q == GUARD_LAST) begin
               state_d = ON;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ON: begin
            if (cnt_q == DIV_LAST) begin
               state_d = BLANK;
               cnt_d   = '0;
               idx_d   = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = BLANK;
            cnt_d   = '0;
         end
      endcase

      // Commit uses the pending value from before this edge, so a same-edge load waits a frame.
      if (frame_end) begin
         frame_done_d = 1'b1;
         if (pending_full_q) begin
            active_d       = pending_q;
            pending_full_d = 1'b0;
         end
         mask_d = lz_mask(32'(active_d), N_DIGITS, load_if.lz_en);
      end

      if (accept) begin
         pending_d      = load_if.load_data;
         pending_full_d = 1'b1;
      end

      load_ready_d = !pending_full_d;
   end

   assign active_ext = 32'(active_d);
   assign nibble     = active_ext[{idx_d, 2'b00} +: 4];

   hex_a_7seg u_hex_a_7seg (
      .nibble (nibble),
      .seg    (seg)
   );

   // Pins are driven from next-state values so the registered outputs line up with state_q.
   always_comb begin
      anodo_d   = AN_OFF;
      catodos_d = SEG_OFF;
      if ((state_d == ON) && !mask_d[idx_d]) begin
         anodo_d[idx_d] = 1'b0;
         catodos_d      = seg;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= BLANK;
         cnt_q          <= '0;
         idx_q          <= 3'd0;
         active_q       <= '0;
         pending_q      <= '0;
         pending_full_q <= 1'b0;
         mask_q         <= '0;
         anodo_q        <= AN_OFF;
         catodos_q      <= SEG_OFF;
         load_ready_q   <= 1'b1;
         frame_done_q   <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         idx_q          <= idx_d;
         active_q       <= active_d;
         pending_q      <= pending_d;
         pending_full_q <= pending_full_d;
         mask_q         <= mask_d;
         anodo_q        <= anodo_d;
         catodos_q      <= catodos_d;
         load_ready_q   <= load_ready_d;
         frame_done_q   <= frame_done_d;
      end
   end

   assign load_if.load_ready = load_ready_q;
   assign anodo              = anodo_q;
   assign catodos            = catodos_q;
   assign frame_done         = frame_done_q;

endmodule

// File: doc/controlador_barrido_display.md
Name: controlador_barrido_display

Overview:
- Time-multiplexed scan controller for the board's 8-digit common-anode 7-segment display.
- Owns the anode/cathode lines and cycles through the digits with an anti-ghosting blank guard between digit slots.
- Accepts new hex digit values through a valid/ready handshake into a shadow buffer, committed only at frame boundaries, so a frame never shows mixed old and new digits.
- Sits between the binary datapath (Gray-to-binary result, converted to digits upstream) and the display pins.

Parameters:
- N_DIGITS, 8, number of digits scanned (1..8); anodo width fixed at 8, unused anodes held high.
- DIV, 100000, clk cycles a digit's anode is on per slot (>=1).
- GUARD, 16, clk cycles all anodes are off before each digit slot (>=1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- load_valid  in  1  load_data is valid this cycle.
- load_data  in  4*N_DIGITS  hex digits; nibble i drives digit i (digit 0 = rightmost).
- load_ready  out  1  shadow buffer empty; a load is accepted when load_valid && load_ready at a rising clk edge.
- lz_en  in  1  leading-zero suppression enable; sampled at commit.
- anodo  out  8  anode enables, active-low.
- catodos  out  7  segments {g,f,e,d,c,b,a}, active-low.
- frame_done  out  1  one-cycle pulse at the end of each full scan.

Behaviour:
- Reset (async assert, sync release):
  - anodo=8'hFF, catodos=7'h7F, load_ready=1, frame_done=0.
  - Active digits = 0, pending buffer empty, digit index 0, suppression mask = 0.
  - FSM enters BLANK with its counter cleared.
- All outputs are registered.
- FSM has two states:
  - BLANK: anodo=8'hFF, catodos=7'h7F. Stays for GUARD cycles, then goes to ON.
  - ON: anodo bit idx = 0 unless digit idx is suppressed; catodos = segment pattern of active[idx], or 7'h7F if suppressed. Stays for DIV cycles, then goes to BLANK with idx+1, wrapping from N_DIGITS-1 to 0.
- Slot length is exactly GUARD+DIV cycles; frame length is N_DIGITS*(GUARD+DIV).
- Segment map, active-low: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10, A=7'h08, b=7'h03, C=7'h46, d=7'h21, E=7'h06, F=7'h0E.
- Handshake:
  - A load is accepted on an edge where load_valid && load_ready; load_data goes into the pending buffer and pending becomes full.
  - load_ready = !pending_full, registered; it drops the cycle after acceptance.
  - load_valid while load_ready=0 is ignored; the upstream holds its data.
- Commit: on the ON→BLANK edge of digit N_DIGITS-1 (the frame end):
  - frame_done pulses for 1 cycle.
  - If pending is full: active <= pending, pending empties, and load_ready returns to 1 on the next cycle.
  - The leading-zero mask is recomputed from the new active value (or the unchanged one) and lz_en.
- Load arriving on the commit edge with pending empty: it is accepted into pending and committed at the next frame end, never the current one.
- Leading-zero suppression:
  - With lz_en=1, every digit above the most significant non-zero digit is suppressed: its anode stays off during its ON slot.
  - Digit 0 is never suppressed, so all-zero data shows a single "0".
  - lz_en changes take effect only at commit.
- Digit index ≥ N_DIGITS is never reached.
- Asserting reset mid-frame immediately blanks the display and discards pending data.

Decomposition:
- Package disp_pkg:
  - State enum {BLANK, ON}.
  - The 16-entry segment constant table.
  - SEG_OFF=7'h7F and AN_OFF=8'hFF.
- Sub-module hex_a_7seg: combinational nibble → catodos pattern. Used for the ON-state cathode value.

Test Plan:
- Params N_DIGITS=4, DIV=4, GUARD=2 (slot 6, frame 24). Release reset with no load → anodo=FF for 2 cycles; then anodo=FE, catodos=7'h40 for 4 cycles; sequence continues FD, FB, F7; frame_done pulses at cycle 24.
- Load 16'h3A7F with valid held high → load_ready low for the rest of the frame. At the frame edge the commit happens, and the next frame shows F, 7, A, 3 on digits 0..3 as 0E, 78, 08, 30. load_ready rises the cycle after the commit.
- Back-to-back loads 16'h1111 then 16'h2222 within one frame → second load is stalled (ready=0) and accepted after the commit. Displayed frames are 1111 and then 2222 in order, never mixed within a frame.
- lz_en=1, load 16'h0050 → digits 2 and 3 are suppressed (anodes FB and F7 never asserted); digits 0 and 1 show 0 and 5. Then load 16'h0000 → only digit 0 shows 7'h40.
- Load asserted exactly on the commit edge with pending empty → data is not visible in the following frame; it appears one frame later.
- Drop rst_n mid-ON of digit 2 → anodo=FF and catodos=7F asynchronously, load_ready=1; after release, the scan restarts at BLANK/digit 0 with zeros displayed.
